// File: rtl/cdb_arb_if.sv
// CDB arbiter bundle: FU requests with branch masks, mispredict squash inputs,
// and the per-FU grants / per-port mux selects returned to the CDB.
interface cdb_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CDB_SZ  = 2,
  parameter int unsigned B_MASK  = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][B_MASK-1:0] req_bm;
  logic [B_MASK-1:0]              b_mm_resolve;
  logic                           b_mm_mispred;
  logic [NUM_REQ-1:0]             gnt;
  logic [CDB_SZ-1:0]              port_valid;
  logic [CDB_SZ-1:0][IDX_W-1:0]   port_sel;
  logic [IDX_W-1:0]               rr_ptr;

  modport master (
    output req, req_bm, b_mm_resolve, b_mm_mispred,
    input  gnt, port_valid, port_sel, rr_ptr
  );

  modport slave (
    input  req, req_bm, b_mm_resolve, b_mm_mispred,
    output gnt, port_valid, port_sel, rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to CDB_SZ FUs per cycle combinationally and
// maps the k-th grant in scan order onto CDB port k; mispredicted work is squashed.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CDB_SZ  = 2,
  parameter int unsigned B_MASK  = 4
) (
  input logic        clock,
  input logic        reset,
  cdb_arb_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]             rr_q;
  logic [IDX_W-1:0]             rr_d;
  logic [NUM_REQ-1:0]           squash;
  logic [NUM_REQ-1:0]           elig;
  logic [NUM_REQ-1:0]           gnt;
  logic [CDB_SZ-1:0]            port_valid;
  logic [CDB_SZ-1:0][IDX_W-1:0] port_sel;

  always_comb begin
    squash = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      squash[i] = bus.b_mm_mispred & (|(bus.req_bm[i] & bus.b_mm_resolve));
    end
    elig = bus.req & ~squash;
  end

  // Scan from rr_q upward with wrap; every output is defaulted so req=0 yields no X.
  always_comb begin
    logic [IDX_W-1:0] idx;
    int unsigned      cnt;
    gnt        = '0;
    port_valid = '0;
    port_sel   = '0;
    rr_d       = rr_q;
    idx        = '0;
    cnt        = 0;
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = IDX_W'((32'(rr_q) + k) % NUM_REQ);
        if (elig[idx] && (cnt < CDB_SZ)) begin
          gnt[idx] = 1'b1;
          for (int unsigned p = 0; p < CDB_SZ; p++) begin
            if (cnt == p) begin
              port_valid[p] = 1'b1;
              port_sel[p]   = idx;
            end
          end
          rr_d = ((32'(idx) + 1) == NUM_REQ) ? '0 : IDX_W'(32'(idx) + 1);
          cnt  = cnt + 1;
        end
      end
    end
  end

  // rr_d already holds rr_q when nothing is granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.port_valid = port_valid;
  assign bus.port_sel   = port_sel;
  assign bus.rr_ptr     = rr_q;
endmodule
